functional_unit: RTL and testbench

- Single-issue, multi-cycle execution unit for the Tomasulo-style core.
- Sits behind the reservation station. It contains its own 8:1 operand selectors that pick Rx and Ry from the register-file snapshot (R1..R7, with R0 reading as zero).
- Executes one ALU operation at a time and broadcasts the result on the common result bus with the reservation-station tag of the issuing entry.

---
 rtl/functional_unit.sv | 147 ++++++++++++++
 tb/tb_functional_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/functional_unit.sv
// Multi-cycle execution unit that sits behind a reservation station.
// It selects its operands from the register snapshot, runs one ALU op at a time and broadcasts the tagged result.
module functional_unit #(
  parameter int DATA_W  = 16,
  parameter int LAT_ALU = 2,
  parameter int LAT_MUL = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] instruction,
  input  logic              enable,
  input  logic [2:0]        tagIn,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  input  logic [DATA_W-1:0] R3,
  input  logic [DATA_W-1:0] R4,
  input  logic [DATA_W-1:0] R5,
  input  logic [DATA_W-1:0] R6,
  input  logic [DATA_W-1:0] R7,
  output logic [2:0]        tagOut,
  output logic              done,
  output logic [DATA_W-1:0] doneInst,
  output logic [DATA_W-1:0] dout,
  output logic              disponivel
);

  localparam int LAT_MAX = (LAT_MUL > LAT_ALU) ? LAT_MUL : LAT_ALU;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  inst_q, inst_d;
  logic [2:0]         tag_q, tag_d;
  logic [DATA_W-1:0]  opA_q, opA_d;
  logic [DATA_W-1:0]  opB_q, opB_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W-1:0]  doneInst_q, doneInst_d;
  logic [2:0]         tagOut_q, tagOut_d;
  logic [DATA_W-1:0]  opA, opB, result;

  // Select 0 is the hardwired zero register.
  function automatic logic [DATA_W-1:0] selReg(input logic [2:0] s);
    case (s)
      3'd1:    selReg = R1;
      3'd2:    selReg = R2;
      3'd3:    selReg = R3;
      3'd4:    selReg = R4;
      3'd5:    selReg = R5;
      3'd6:    selReg = R6;
      3'd7:    selReg = R7;
      default: selReg = '0;
    endcase
  endfunction

  assign opA = selReg(instruction[9:7]);
  assign opB = selReg(instruction[6:4]);

  always_comb begin
    result = '0;
    case (inst_q[3:0])
      OP_ADD:  result = opA_q + opB_q;
      OP_SUB:  result = opA_q - opB_q;
      OP_MUL:  result = opA_q * opB_q;
      OP_AND:  result = opA_q & opB_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      inst_q     <= '0;
      tag_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      done_q     <= 1'b0;
      dout_q     <= '0;
      doneInst_q <= '0;
      tagOut_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      tag_q      <= tag_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
      doneInst_q <= doneInst_d;
      tagOut_q   <= tagOut_d;
    end
  end

  // The counter holds the remaining edges minus one, so completion is registered exactly L edges after issue.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    tag_d      = tag_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    done_d     = 1'b0;
    dout_d     = dout_q;
    doneInst_d = doneInst_q;
    tagOut_d   = tagOut_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_BUSY;
          inst_d  = instruction;
          tag_d   = tagIn;
          opA_d   = opA;
          opB_d   = opB;
          cnt_d   = (instruction[3:0] == OP_MUL) ? CNT_W'(LAT_MUL - 1) : CNT_W'(LAT_ALU - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          dout_d     = result;
          doneInst_d = inst_q;
          tagOut_d   = tag_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign disponivel = (state_q == S_IDLE);
  assign done       = done_q;
  assign dout       = dout_q;
  assign doneInst   = doneInst_q;
  assign tagOut     = tagOut_q;

endmodule

// File: tb/tb_functional_unit.sv
// Randomized bench for functional_unit, checked against a completion-time reference model.
module tb_functional_unit;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] instruction = '0;
  logic        enable = 1'b0;
  logic [2:0]  tagIn = '0;
  logic [15:0] rf [0:7];
  logic [2:0]  tagOut;
  logic        done;
  logic [15:0] doneInst;
  logic [15:0] dout;
  logic        disponivel;

  int compared = 0;
  int mismatched = 0;

  longint      n = 0;
  longint      doneEdge = 0;
  bit          pending = 0;
  logic [15:0] pendDout, pendInst, heldDout, heldInst;
  logic [2:0]  pendTag, heldTag;

  functional_unit #(.DATA_W(16), .LAT_ALU(2), .LAT_MUL(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .instruction(instruction), .enable(enable), .tagIn(tagIn),
    .R1(rf[1]), .R2(rf[2]), .R3(rf[3]), .R4(rf[4]), .R5(rf[5]), .R6(rf[6]), .R7(rf[7]),
    .tagOut(tagOut), .done(done), .doneInst(doneInst), .dout(dout), .disponivel(disponivel)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic [2:0] rz);
    return {3'b000, rz, ry, rx, op};
  endfunction

  function automatic logic [15:0] modelResult(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd4:    return p[15:0];
      4'd5:    return a & b;
      default: return 16'h0000;
    endcase
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs, then let the model see the rising edge.
  task automatic applyStimulus(input logic en, input logic [15:0] ins, input logic [2:0] tg);
    logic        expDisp, expDone, accept;
    logic [15:0] nDout;
    int          lat;
    @(negedge Clock);
    expDisp = !pending || (n >= doneEdge);
    expDone = pending && (n == doneEdge);
    if (expDone) begin
      heldDout = pendDout;
      heldInst = pendInst;
      heldTag  = pendTag;
    end
    checkOutput("done", 16'(done), 16'(expDone));
    checkOutput("disponivel", 16'(disponivel), 16'(expDisp));
    checkOutput("dout", dout, heldDout);
    checkOutput("doneInst", doneInst, heldInst);
    checkOutput("tagOut", 16'(tagOut), 16'(heldTag));
    enable      = en;
    instruction = ins;
    tagIn       = tg;
    accept = en && expDisp;
    nDout  = modelResult(ins[3:0], rf[ins[9:7]], rf[ins[6:4]]);
    lat    = (ins[3:0] == 4'd4) ? 4 : 2;
    @(posedge Clock);
    n++;
    if (accept) begin
      pending  = 1;
      doneEdge = n + lat;
      pendDout = nDout;
      pendInst = ins;
      pendTag  = tg;
    end
    #1;
  endtask

  task automatic doReset();
    #2 Resetn = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_disponivel", 16'(disponivel), 16'h1);
    checkOutput("rst_dout", dout, 16'h0);
    checkOutput("rst_doneInst", doneInst, 16'h0);
    checkOutput("rst_tagOut", 16'(tagOut), 16'h0);
    pending  = 0;
    heldDout = '0;
    heldInst = '0;
    heldTag  = '0;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'h0, 3'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    heldDout = '0; heldInst = '0; heldTag = '0;
    pendDout = '0; pendInst = '0; pendTag = '0;
    doReset();
    idle(2);

    rf[2] = 16'd5; rf[3] = 16'd7;
    applyStimulus(1'b1, mk(4'd0, 3'd3, 3'd2, 3'd1), 3'd4);
    idle(2);
    checkOutput("add_result", dout, 16'd12);
    checkOutput("add_tag", 16'(tagOut), 16'd4);
    checkOutput("add_inst", doneInst, mk(4'd0, 3'd3, 3'd2, 3'd1));

    rf[1] = 16'd1;
    applyStimulus(1'b1, mk(4'd1, 3'd1, 3'd0, 3'd2), 3'd3);
    idle(2);
    checkOutput("sub_wrap", dout, 16'hFFFF);

    rf[4] = 16'd300; rf[5] = 16'd300;
    applyStimulus(1'b1, mk(4'd4, 3'd5, 3'd4, 3'd1), 3'd7);
    rf[4] = 16'd1; rf[5] = 16'd2;
    idle(4);
    checkOutput("mul_result", dout, 16'h5F90);
    checkOutput("mul_tag", 16'(tagOut), 16'd7);

    applyStimulus(1'b1, mk(4'd0, 3'd3, 3'd2, 3'd1), 3'd1);
    applyStimulus(1'b1, mk(4'd1, 3'd3, 3'd2, 3'd1), 3'd2);
    idle(4);
    checkOutput("drop_tag", 16'(tagOut), 16'd1);

    rf[2] = 16'd100; rf[3] = 16'd23;
    applyStimulus(1'b1, mk(4'd0, 3'd3, 3'd2, 3'd1), 3'd5);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(4'd0, 3'd2, 3'd2, 3'd1), 3'd6);
    idle(1);
    checkOutput("b2b_result", dout, 16'd200);
    checkOutput("b2b_tag", 16'(tagOut), 16'd6);

    applyStimulus(1'b1, mk(4'hF, 3'd3, 3'd2, 3'd1), 3'd0);
    idle(2);
    checkOutput("nop_result", dout, 16'h0000);

    applyStimulus(1'b1, mk(4'd4, 3'd5, 3'd4, 3'd1), 3'd7);
    idle(1);
    doReset();
    idle(6);

    for (int c = 0; c < 400; c++) begin
      for (int r = 1; r < 8; r++) if ($urandom_range(0, 3) == 0) rf[r] = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       op = 4'd0;
        1:       op = 4'd1;
        2:       op = 4'd4;
        3:       op = 4'd5;
        default: op = 4'($urandom);
      endcase
      ins = 16'($urandom);
      ins[3:0] = op;
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus($urandom_range(0, 2) != 0, ins, 3'($urandom));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
